lcd_cmd_feeder: RTL and testbench

//  Upstream command source for the LCD controller. Buffers host opcodes in a small FIFO and

---
 rtl/lcd_cmd_feeder.sv | 122 ++++++++++++
 tb/tb_lcd_cmd_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_feeder.sv
// rtl/lcd_cmd_feeder.sv - opcode FIFO and per-window command issuer for the LCD controller
module lcd_cmd_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    in_cmd,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          busy,
  input  logic          done,
  output logic [3:0]    cmd,
  output logic          cmd_valid,
  output logic          frame_done,
  output logic          drop_err,
  output logic [7:0]    issued_cnt,
  output logic [AW:0]   level
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Highest legal opcode; 12..15 are rejected at the input.
  localparam logic [3:0]  MAX_OPCODE = 4'd11;
  localparam logic [3:0]  OP_WRITE   = 4'd0;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  state_t          state;
  logic [3:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            legal;
  logic            push;
  logic            drop;
  logic            accept;
  logic [3:0]      head;

  // Input qualification: only legal opcodes offered while there is room are stored.
  always_comb begin
    in_ready = (level != FULL_LEVEL);
    legal    = (in_cmd <= MAX_OPCODE);
    push     = in_valid & in_ready & legal;
    drop     = in_valid & in_ready & ~legal;
  end

  // Issue offer must be combinational: the controller samples it in the single busy-low cycle.
  always_comb begin
    head      = mem[rd_ptr];
    cmd       = (level != '0) ? head : 4'd0;
    cmd_valid = (state == READY) & (level != '0) & ~busy;
    accept    = cmd_valid;
  end

  // FIFO storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, accept})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Issue FSM with registered pulse outputs and accepted-command counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= READY;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
      issued_cnt <= 8'd0;
    end else begin
      frame_done <= 1'b0;
      drop_err   <= drop;
      if (accept) begin
        issued_cnt <= issued_cnt + 8'd1;
      end
      case (state)
        READY: begin
          if (accept) begin
            state <= (head == OP_WRITE) ? WAIT_DONE : WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // Hold off until busy rises so a long busy-low stretch issues only once.
          if (busy) begin
            state <= READY;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            state      <= READY;
            frame_done <= 1'b1;
          end
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_feeder.sv
// tb/tb_lcd_cmd_feeder.sv - directed self-checking bench for lcd_cmd_feeder
module tb_lcd_cmd_feeder;

  logic       clk;
  logic       reset;
  logic [3:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       frame_done;
  logic       drop_err;
  logic [7:0] issued_cnt;
  logic [3:0] level;

  int total;
  int bad;

  lcd_cmd_feeder #(.DEPTH(8), .AW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_cmd     (in_cmd),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .frame_done (frame_done),
    .drop_err   (drop_err),
    .issued_cnt (issued_cnt),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0; busy = 1'b1; done = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push(input logic [3:0] op);
    in_cmd = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // One busy-low window followed by busy returning high.
  task automatic window();
    busy = 1'b0;
    step();
    busy = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (level !== 4'd0 || in_ready !== 1'b1 || cmd !== 4'd0 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_init level=%0d in_ready=%0d cmd=%0d cmd_valid=%0d want 0 1 0 0", level, in_ready, cmd, cmd_valid);
    end
    push(4'd3); push(4'd7);
    busy = 1'b0;
    step();
    total++; if (issued_cnt !== 8'd1) begin
      bad++; $display("FAIL reset_pre_issue got=%0d want=1", issued_cnt);
    end
    reset = 1'b1;
    #1;
    total++; if (level !== 4'd0 || issued_cnt !== 8'd0 || cmd !== 4'd0 || cmd_valid !== 1'b0 ||
                 frame_done !== 1'b0 || drop_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid level=%0d cnt=%0d cmd=%0d cv=%0d fd=%0d de=%0d rdy=%0d want 0 0 0 0 0 0 1",
                      level, issued_cnt, cmd, cmd_valid, frame_done, drop_err, in_ready);
    end
    step();
    reset = 1'b0;
    busy = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_no_offer got=%0d want=0", cmd_valid);
    end
    busy = 1'b1;
    step();
  endtask

  task automatic test_issue();
    do_reset();
    push(4'd4); push(4'd5); push(4'd0);
    total++; if (level !== 4'd3 || cmd !== 4'd4 || cmd_valid !== 1'b0) begin
      bad++; $display("FAIL issue_queued level=%0d cmd=%0d cv=%0d want 3 4 0", level, cmd, cmd_valid);
    end
    busy = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd4) begin
      bad++; $display("FAIL issue_offer cv=%0d cmd=%0d want 1 4", cmd_valid, cmd);
    end
    step();
    busy = 1'b1;
    total++; if (level !== 4'd2 || issued_cnt !== 8'd1 || cmd !== 4'd5) begin
      bad++; $display("FAIL issue_after level=%0d cnt=%0d cmd=%0d want 2 1 5", level, issued_cnt, cmd);
    end
    step();
  endtask

  task automatic test_window();
    int accepts;
    do_reset();
    push(4'd1); push(4'd2);
    accepts = 0;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (cmd_valid === 1'b1) accepts++;
      @(posedge clk);
      #1;
    end
    total++; if (accepts !== 1 || issued_cnt !== 8'd1 || level !== 4'd1) begin
      bad++; $display("FAIL window_once accepts=%0d cnt=%0d level=%0d want 1 1 1", accepts, issued_cnt, level);
    end
    busy = 1'b1;
    step();
    busy = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd2) begin
      bad++; $display("FAIL window_second cv=%0d cmd=%0d want 1 2", cmd_valid, cmd);
    end
    step();
    busy = 1'b1;
    total++; if (issued_cnt !== 8'd2 || level !== 4'd0) begin
      bad++; $display("FAIL window_drain cnt=%0d level=%0d want 2 0", issued_cnt, level);
    end
    step();
  endtask

  task automatic test_full();
    logic [3:0] expect_q [$];
    do_reset();
    for (int i = 1; i <= 8; i++) push(4'(i));
    total++; if (level !== 4'd8 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_level level=%0d in_ready=%0d want 8 0", level, in_ready);
    end
    push(4'd9);
    total++; if (level !== 4'd8 || cmd !== 4'd1) begin
      bad++; $display("FAIL full_ignore level=%0d cmd=%0d want 8 1", level, cmd);
    end
    push(4'd14);
    total++; if (drop_err !== 1'b0 || level !== 4'd8) begin
      bad++; $display("FAIL full_no_drop drop_err=%0d level=%0d want 0 8", drop_err, level);
    end
    // Pop while full with a push pending: push refused, level falls.
    in_cmd = 4'd10; in_valid = 1'b1; busy = 1'b0;
    step();
    in_valid = 1'b0; busy = 1'b1;
    total++; if (level !== 4'd7 || issued_cnt !== 8'd1) begin
      bad++; $display("FAIL full_pop level=%0d cnt=%0d want 7 1", level, issued_cnt);
    end
    step();
    // Simultaneous push and pop with room: level unchanged; write pointer has wrapped.
    in_cmd = 4'd11; in_valid = 1'b1; busy = 1'b0;
    step();
    in_valid = 1'b0; busy = 1'b1;
    total++; if (level !== 4'd7 || issued_cnt !== 8'd2 || cmd !== 4'd3) begin
      bad++; $display("FAIL full_push_pop level=%0d cnt=%0d cmd=%0d want 7 2 3", level, issued_cnt, cmd);
    end
    step();
    expect_q = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11};
    foreach (expect_q[i]) begin
      busy = 1'b0;
      #1;
      total++; if (cmd_valid !== 1'b1 || cmd !== expect_q[i]) begin
        bad++; $display("FAIL full_order idx=%0d cv=%0d cmd=%0d want 1 %0d", i, cmd_valid, cmd, expect_q[i]);
      end
      step();
      busy = 1'b1;
      step();
    end
    total++; if (level !== 4'd0 || issued_cnt !== 8'd9) begin
      bad++; $display("FAIL full_empty level=%0d cnt=%0d want 0 9", level, issued_cnt);
    end
  endtask

  task automatic test_drop();
    do_reset();
    in_cmd = 4'd13; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || drop_err !== 1'b0) begin
      bad++; $display("FAIL drop_pre in_ready=%0d drop_err=%0d want 1 0", in_ready, drop_err);
    end
    step();
    in_valid = 1'b0;
    total++; if (drop_err !== 1'b1 || level !== 4'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL drop_pulse drop_err=%0d level=%0d in_ready=%0d want 1 0 1", drop_err, level, in_ready);
    end
    step();
    total++; if (drop_err !== 1'b0) begin
      bad++; $display("FAIL drop_clear got=%0d want=0", drop_err);
    end
  endtask

  task automatic test_write();
    do_reset();
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (frame_done !== 1'b0) begin
      bad++; $display("FAIL write_stray_done got=%0d want=0", frame_done);
    end
    push(4'd0); push(4'd6);
    window();
    total++; if (issued_cnt !== 8'd1 || level !== 4'd1) begin
      bad++; $display("FAIL write_issue cnt=%0d level=%0d want 1 1", issued_cnt, level);
    end
    busy = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b0) begin
      bad++; $display("FAIL write_hold got=%0d want=0", cmd_valid);
    end
    step();
    busy = 1'b1;
    step();
    total++; if (issued_cnt !== 8'd1 || frame_done !== 1'b0) begin
      bad++; $display("FAIL write_wait cnt=%0d fd=%0d want 1 0", issued_cnt, frame_done);
    end
    done = 1'b1;
    step();
    done = 1'b0;
    total++; if (frame_done !== 1'b1) begin
      bad++; $display("FAIL write_frame_done got=%0d want=1", frame_done);
    end
    step();
    total++; if (frame_done !== 1'b0) begin
      bad++; $display("FAIL write_fd_clear got=%0d want=0", frame_done);
    end
    busy = 1'b0;
    #1;
    total++; if (cmd_valid !== 1'b1 || cmd !== 4'd6) begin
      bad++; $display("FAIL write_next cv=%0d cmd=%0d want 1 6", cmd_valid, cmd);
    end
    step();
    busy = 1'b1;
    total++; if (issued_cnt !== 8'd2 || level !== 4'd0) begin
      bad++; $display("FAIL write_after cnt=%0d level=%0d want 2 0", issued_cnt, level);
    end
    step();
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) begin
      push(4'd2);
      window();
    end
    total++; if (issued_cnt !== 8'd255) begin
      bad++; $display("FAIL cnt_255 got=%0d want=255", issued_cnt);
    end
    push(4'd2);
    window();
    total++; if (issued_cnt !== 8'd0) begin
      bad++; $display("FAIL cnt_wrap got=%0d want=0", issued_cnt);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1; in_valid = 1'b0; in_cmd = 4'd0; busy = 1'b1; done = 1'b0;
    test_reset();
    test_issue();
    test_window();
    test_full();
    test_drop();
    test_write();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
